// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer.
//   seq_state_e : controller states (IDLE/APPLY/HOLD/SAMPLE/DONE, 3-bit encoding)
//   TtAnd/TtOr/TtXor : two-input truth tables; bit k = expected y for vector k
//   hold_width() : counter width able to hold HOLD_CYCLES-1
package truth_table_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StApply  = 3'd1,
        StHold   = 3'd2,
        StSample = 3'd3,
        StDone   = 3'd4
    } seq_state_e;

    localparam logic [3:0] TtAnd = 4'b1000;
    localparam logic [3:0] TtOr  = 4'b1110;
    localparam logic [3:0] TtXor = 4'b0110;

    // The timer is loaded with hold_cycles-1, so it needs clog2(hold_cycles) bits (at least 1).
    function automatic int unsigned hold_width(input int unsigned hold_cycles);
        if (hold_cycles <= 2) begin
            return 1;
        end
        return $clog2(hold_cycles);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_hold_timer.sv
// Loadable down-counter with a terminal-count flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load LOAD into the counter (takes priority over en)
//   en         : decrement by one while the count is non-zero
//   tc         : count is zero
module truth_table_sequencer_hold_timer #(
    parameter int unsigned         WIDTH = 4,
    parameter logic [WIDTH-1:0]    LOAD  = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - One;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Stimulus controller that sweeps all 2**N_IN input vectors of a combinational gate,
// holds each for HOLD_CYCLES clocks, samples y and checks it against EXPECTED.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : 1-cycle pulse, accepted in IDLE or DONE
//   abort      : level, forces IDLE on the next edge (highest priority)
//   vec        : registered gate inputs
//   y          : gate output
//   busy       : sweep in progress
//   done       : sweep finished, results valid
//   pass       : done with no mismatches
//   err_count  : mismatching vectors in the current sweep
//   fail_map   : bit k set if vector k mismatched
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int unsigned            N_IN        = 2,
    parameter int unsigned            HOLD_CYCLES = 10,
    parameter logic [2**N_IN-1:0]     EXPECTED    = TtAnd
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       vec,
    input  logic                  y,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_IN:0]         err_count,
    output logic [2**N_IN-1:0]    fail_map
);

    localparam int unsigned           TimerW    = hold_width(HOLD_CYCLES);
    localparam logic [TimerW-1:0]     TimerLoad = TimerW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]       IdxLast   = '1;
    localparam logic [N_IN-1:0]       IdxOne    = N_IN'(1);
    localparam logic [N_IN:0]         ErrOne    = (N_IN + 1)'(1);

    seq_state_e            state_d, state_q;
    logic [N_IN-1:0]       idx_d, idx_q;
    logic [N_IN-1:0]       vec_d, vec_q;
    logic [N_IN:0]         err_d, err_q;
    logic [2**N_IN-1:0]    fail_d, fail_q;
    logic                  timer_load, timer_en, timer_tc;

    truth_table_sequencer_hold_timer #(
        .WIDTH (TimerW),
        .LOAD  (TimerLoad)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        err_d      = err_q;
        fail_d     = fail_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        if (abort) begin
            // Partial results are kept for inspection; only the gate inputs are parked.
            state_d = StIdle;
            vec_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StApply;
                        idx_d   = '0;
                        err_d   = '0;
                        fail_d  = '0;
                    end
                end
                StApply: begin
                    vec_d      = idx_q;
                    timer_load = 1'b1;
                    state_d    = StHold;
                end
                StHold: begin
                    timer_en = 1'b1;
                    if (timer_tc) begin
                        state_d = StSample;
                    end
                end
                StSample: begin
                    if (y != EXPECTED[idx_q]) begin
                        err_d         = err_q + ErrOne;
                        fail_d[idx_q] = 1'b1;
                    end
                    // idx stops at the last vector so it never wraps.
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        state_d = StApply;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = (state_q == StApply) || (state_q == StHold) || (state_q == StSample);
    assign done      = (state_q == StDone);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_map  = fail_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gate_or = 1'b0;
    logic [1:0] vec;
    logic       y;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_map;

    logic       start1 = 1'b0;
    logic [0:0] vec1;
    logic       y1;
    logic       busy1, done1, pass1;
    logic [1:0] err_count1;
    logic [1:0] fail_map1;

    int errors = 0;
    int checks = 0;
    int t = 0;

    always #5 clk = ~clk;

    // Gate under test: AND, or OR to provoke mismatches against the AND table.
    assign y  = gate_or ? (vec[1] | vec[0]) : (vec[1] & vec[0]);
    assign y1 = ~vec1[0];

    truth_table_sequencer #(
        .N_IN        (2),
        .HOLD_CYCLES (10),
        .EXPECTED    (4'b1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec       (vec),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_map  (fail_map)
    );

    truth_table_sequencer #(
        .N_IN        (1),
        .HOLD_CYCLES (1),
        .EXPECTED    (2'b01)
    ) dut_inv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .abort     (1'b0),
        .vec       (vec1),
        .y         (y1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err_count1),
        .fail_map  (fail_map1)
    );

    // t counts rising edges since the start edge; sampling happens on falling edges.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t = 0;
    endtask

    task automatic advance_to(input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({vec, busy, done, pass, err_count, fail_map} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", {vec, busy, done, pass, err_count, fail_map});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_and_sweep();
        gate_or = 1'b0;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            advance_to(12 * k + 6);
            checks++;
            if (vec !== 2'(k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL and_vec%0d: vec=%b busy=%b required %b 1", k, vec, busy, 2'(k));
            end
        end
        advance_to(47);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL and_done_early: done=%b busy=%b required 0 1", done, busy);
        end
        advance_to(48);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 3'd0
            || fail_map !== 4'b0000 || vec !== 2'b11) begin
            errors++;
            $display("FAIL and_result: done=%b busy=%b pass=%b err=%0d map=%b vec=%b required 1 0 1 0 0000 11",
                     done, busy, pass, err_count, fail_map, vec);
        end
    endtask

    task automatic test_or_mismatch();
        gate_or = 1'b1;
        pulse_start();
        checks++;
        if (err_count !== 3'd0 || fail_map !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL or_restart_clear: err=%0d map=%b busy=%b required 0 0000 1",
                     err_count, fail_map, busy);
        end
        advance_to(48);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 3'd2 || fail_map !== 4'b0110) begin
            errors++;
            $display("FAIL or_result: done=%b pass=%b err=%0d map=%b required 1 0 2 0110",
                     done, pass, err_count, fail_map);
        end
        gate_or = 1'b0;
    endtask

    task automatic test_start_while_busy();
        pulse_start();
        advance_to(20);
        start = 1'b1;
        advance_to(21);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || vec !== 2'b01) begin
            errors++;
            $display("FAIL busy_restart_vec: busy=%b vec=%b required 1 01", busy, vec);
        end
        advance_to(47);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL busy_restart_early: done=%b required 0", done);
        end
        advance_to(48);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_restart_done: done=%b pass=%b required 1 1", done, pass);
        end
    endtask

    task automatic test_abort();
        gate_or = 1'b1;
        pulse_start();
        advance_to(30);
        abort = 1'b1;
        start = 1'b1;
        advance_to(31);
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec !== 2'b00 || err_count !== 3'd1
            || fail_map !== 4'b0010) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b vec=%b err=%0d map=%b required 0 0 00 1 0010",
                     busy, done, vec, err_count, fail_map);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stays_idle: busy=%b done=%b required 0 0", busy, done);
        end
        gate_or = 1'b0;
        pulse_start();
        checks++;
        if (err_count !== 3'd0 || fail_map !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_fresh_clear: err=%0d map=%b busy=%b required 0 0000 1",
                     err_count, fail_map, busy);
        end
        advance_to(47);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_fresh_early: done=%b required 0", done);
        end
        advance_to(48);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 3'd0) begin
            errors++;
            $display("FAIL abort_fresh_done: done=%b pass=%b err=%0d required 1 1 0",
                     done, pass, err_count);
        end
    endtask

    task automatic test_reset_mid_sweep();
        gate_or = 1'b1;
        pulse_start();
        advance_to(25);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec, busy, done, pass, err_count, fail_map} !== 12'd0) begin
            errors++;
            $display("FAIL midreset_async: got %b required 0", {vec, busy, done, pass, err_count, fail_map});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gate_or = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec !== 2'b00 || err_count !== 3'd0) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b done=%b vec=%b err=%0d required 0 0 00 0",
                     busy, done, vec, err_count);
        end
    endtask

    task automatic test_inverter();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        t = 0;
        advance_to(2);
        checks++;
        if (vec1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL inv_vec0: vec=%b busy=%b required 0 1", vec1, busy1);
        end
        advance_to(5);
        checks++;
        if (vec1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL inv_vec1: vec=%b done=%b required 1 0", vec1, done1);
        end
        advance_to(6);
        checks++;
        if (done1 !== 1'b1 || pass1 !== 1'b1 || err_count1 !== 2'd0 || fail_map1 !== 2'b00) begin
            errors++;
            $display("FAIL inv_result: done=%b pass=%b err=%0d map=%b required 1 1 0 00",
                     done1, pass1, err_count1, fail_map1);
        end
    endtask

    initial begin
        test_reset();
        test_and_sweep();
        test_or_mismatch();
        test_start_while_busy();
        test_abort();
        test_reset_mid_sweep();
        test_inverter();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
